// File: rtl/aes_job_sched.sv
`default_nettype none
//============================================================================
// Module  : aes_job_sched
// Brief   : Round-robin scheduler sharing one aes_core and key ROM between
//           N_REQ requesters. It keeps a one-entry expanded-key cache.
// Revision: 1.0
//============================================================================
module aes_job_sched #(
    parameter int N_REQ      = 4,
    parameter int AES_LEN    = 128,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*ADDR_WIDTH-1:0]  req_key_addr,
    input  logic [N_REQ*AES_LEN-1:0]     req_block,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [$clog2(N_REQ)-1:0]     resp_id,
    output logic [AES_LEN-1:0]           resp_result,
    output logic                         busy,
    output logic                         key_en,
    output logic [ADDR_WIDTH-1:0]        key_addr,
    input  logic [AES_LEN-1:0]           key_data,
    output logic                         core_init,
    output logic                         core_next,
    output logic [2*AES_LEN-1:0]         core_key,
    output logic [AES_LEN-1:0]           core_block,
    input  logic                         core_ready,
    input  logic                         core_result_valid,
    input  logic [AES_LEN-1:0]           core_result
);

    localparam int c_ID_W = $clog2(N_REQ);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_KEY_FETCH = 3'd1;
    localparam logic [2:0] c_ST_KEY_LATCH = 3'd2;
    localparam logic [2:0] c_ST_KEY_INIT  = 3'd3;
    localparam logic [2:0] c_ST_KEY_WAIT  = 3'd4;
    localparam logic [2:0] c_ST_BLK_NEXT  = 3'd5;
    localparam logic [2:0] c_ST_BLK_WAIT  = 3'd6;
    localparam logic [2:0] c_ST_RESP      = 3'd7;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic                  r_first;
    logic [c_ID_W-1:0]     r_rr_last;
    logic [c_ID_W-1:0]     r_job_id;
    logic [ADDR_WIDTH-1:0] r_job_addr;
    logic [AES_LEN-1:0]    r_block;
    logic                  r_key_loaded;
    logic [ADDR_WIDTH-1:0] r_cached_addr;
    logic [AES_LEN-1:0]    r_cached_key;
    logic [c_ID_W-1:0]     r_resp_id;
    logic [AES_LEN-1:0]    r_resp_result;

    logic                  w_found;
    logic [c_ID_W-1:0]     w_grant_id;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [AES_LEN-1:0]    w_sel_block;
    int                    w_best;
    int                    w_dist;

    // Grant goes to the requester closest after r_rr_last in circular order.
    always_comb begin
        w_found     = 1'b0;
        w_grant_id  = '0;
        w_sel_addr  = '0;
        w_sel_block = '0;
        w_best      = N_REQ;
        w_dist      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = (i + N_REQ - 1 - int'(r_rr_last)) % N_REQ;
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_found     = 1'b1;
                w_grant_id  = c_ID_W'(i);
                w_sel_addr  = req_key_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_block = req_block[i*AES_LEN +: AES_LEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= (w_next != r_state);
        end
    end

    // The wait states skip their first cycle so stale core status is not taken.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    if (!r_key_loaded || (w_sel_addr != r_cached_addr)) begin
                        w_next = c_ST_KEY_FETCH;
                    end else begin
                        w_next = c_ST_BLK_NEXT;
                    end
                end
            end
            c_ST_KEY_FETCH: w_next = c_ST_KEY_LATCH;
            c_ST_KEY_LATCH: w_next = c_ST_KEY_INIT;
            c_ST_KEY_INIT:  w_next = c_ST_KEY_WAIT;
            c_ST_KEY_WAIT:  if (!r_first && core_ready) w_next = c_ST_BLK_NEXT;
            c_ST_BLK_NEXT:  w_next = c_ST_BLK_WAIT;
            c_ST_BLK_WAIT:  if (!r_first && core_ready && core_result_valid) w_next = c_ST_RESP;
            c_ST_RESP:      if (resp_ready) w_next = c_ST_IDLE;
            default:        w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != c_ST_IDLE);
        key_en     = (r_state == c_ST_KEY_FETCH);
        key_addr   = (r_state == c_ST_KEY_FETCH) ? r_job_addr : '0;
        core_init  = (r_state == c_ST_KEY_INIT);
        core_next  = (r_state == c_ST_BLK_NEXT);
        resp_valid = (r_state == c_ST_RESP);
        req_ready  = '0;
        if ((r_state == c_ST_IDLE) && w_found) begin
            req_ready[w_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last     <= c_ID_W'(N_REQ - 1);
            r_job_id      <= '0;
            r_job_addr    <= '0;
            r_block       <= '0;
            r_key_loaded  <= 1'b0;
            r_cached_addr <= '0;
            r_cached_key  <= '0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
        end else begin
            if ((r_state == c_ST_IDLE) && w_found) begin
                r_job_id   <= w_grant_id;
                r_job_addr <= w_sel_addr;
                r_block    <= w_sel_block;
                r_rr_last  <= w_grant_id;
            end
            if (r_state == c_ST_KEY_LATCH) begin
                r_cached_key  <= key_data;
                r_cached_addr <= r_job_addr;
                r_key_loaded  <= 1'b0;
            end
            if ((r_state == c_ST_KEY_WAIT) && !r_first && core_ready) begin
                r_key_loaded <= 1'b1;
            end
            if ((r_state == c_ST_BLK_WAIT) && !r_first && core_ready && core_result_valid) begin
                r_resp_result <= core_result;
                r_resp_id     <= r_job_id;
            end
        end
    end

    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign core_key    = {r_cached_key, {AES_LEN{1'b0}}};
    assign core_block  = r_block;

endmodule
`default_nettype wire
